// File: rtl/lpf_sched.sv
// lpf_sched: time-multiplexed scheduler for CH first-order unsigned low-pass
// IIR filters sharing one subtract/shift/accumulate datapath.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   start_i          sample strobe, requests one sweep over all channels
//   data_i           CH packed samples, channel k at [k*DATA_W +: DATA_W]
//   cfg_wr_i         write strobe for a channel's cutoff shift
//   cfg_ch_i         target channel of the shift write
//   cfg_shr_i        shift value to write
//   clr_i            clears the sticky overflow flag
//   lp_o             CH packed filter outputs, same packing as data_i
//   busy_o           sweep in progress
//   done_o           one-cycle pulse when a sweep completes
//   ovf_o            sticky: a start request was dropped
module lpf_sched #(
    parameter int unsigned CH      = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SHR_W   = 4,
    parameter int unsigned SHR_DEF = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [CH*DATA_W-1:0]  data_i,
    input  logic                  cfg_wr_i,
    input  logic [$clog2(CH)-1:0] cfg_ch_i,
    input  logic [SHR_W-1:0]      cfg_shr_i,
    input  logic                  clr_i,
    output logic [CH*DATA_W-1:0]  lp_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o
);

    localparam int unsigned     CH_W    = $clog2(CH);
    localparam int unsigned     HP_W    = DATA_W + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CH_W-1:0]        r_ch;
    logic                   r_pend;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;
    logic [DATA_W-1:0]      r_snap [CH];
    logic [DATA_W-1:0]      r_lp   [CH];
    logic [SHR_W-1:0]       r_shr  [CH];
    logic                   r_wb_vld;
    logic [CH_W-1:0]        r_wb_ch;
    logic signed [HP_W-1:0] r_wb_hp;

    logic                   w_accept;
    logic                   w_req_drop;
    logic signed [HP_W-1:0] w_hp;
    logic signed [HP_W-1:0] w_hp_shr;
    logic [DATA_W-1:0]      w_wb_sum;

    // A sweep starts from IDLE on a fresh strobe or a queued one.
    assign w_accept   = (r_state == S_IDLE) && (start_i || r_pend);
    // Only one request can be queued; any further strobe is lost.
    assign w_req_drop = start_i && r_pend;

    // Issue stage: signed high-pass term, arithmetic shift sets the cutoff.
    assign w_hp     = $signed({1'b0, r_snap[r_ch]}) - $signed({1'b0, r_lp[r_ch]});
    assign w_hp_shr = w_hp >>> r_shr[r_ch];

    // Writeback: accumulate modulo 2^DATA_W.
    assign w_wb_sum = DATA_W'({1'b0, r_lp[r_wb_ch]} + $unsigned(r_wb_hp));

    // Sweep sequencing, start queueing and status flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_req_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_i) begin
                r_ovf <= 1'b0;
            end

            if (w_accept) begin
                r_pend <= 1'b0;
            end else if (start_i && r_busy) begin
                r_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_ch == LAST_CH) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_ch <= r_ch + CH_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Snapshot, issue pipeline register, filter state and shift config.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < CH; k++) begin
                r_snap[k] <= '0;
                r_lp[k]   <= '0;
                r_shr[k]  <= SHR_W'(SHR_DEF);
            end
            r_wb_vld <= 1'b0;
            r_wb_ch  <= '0;
            r_wb_hp  <= '0;
        end else begin
            if (w_accept) begin
                for (int unsigned k = 0; k < CH; k++) begin
                    r_snap[k] <= data_i[k*DATA_W +: DATA_W];
                end
            end

            r_wb_vld <= (r_state == S_RUN);
            r_wb_ch  <= r_ch;
            r_wb_hp  <= w_hp_shr;

            // Each channel is written once per sweep, so no RAW hazard with issue.
            if (r_wb_vld) begin
                r_lp[r_wb_ch] <= w_wb_sum;
            end

            if (cfg_wr_i) begin
                r_shr[cfg_ch_i] <= cfg_shr_i;
            end
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign ovf_o  = r_ovf;

    for (genvar k = 0; k < CH; k++) begin : g_lp_o
        assign lp_o[k*DATA_W +: DATA_W] = r_lp[k];
    end

endmodule

// File: tb/tb_lpf_sched.sv
// tb_lpf_sched: directed bench for lpf_sched (CH=4, DATA_W=8). A reference
// model computes each sweep's expected outputs, which are queued when the
// sweep is launched and compared against lp_o when done_o pulses.
module tb_lpf_sched;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 8;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            start_i;
    logic [CH*DW-1:0] data_i;
    logic            cfg_wr_i;
    logic [1:0]      cfg_ch_i;
    logic [3:0]      cfg_shr_i;
    logic            clr_i;
    logic [CH*DW-1:0] lp_o;
    logic            busy_o;
    logic            done_o;
    logic            ovf_o;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] sb [$];
    logic [7:0]  m_lp [CH];
    logic [7:0]  m_x  [CH];
    int          m_shr [CH];
    logic [7:0]  exp_ch1 [3];

    lpf_sched #(
        .CH      (CH),
        .DATA_W  (DW),
        .SHR_W   (4),
        .SHR_DEF (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .data_i    (data_i),
        .cfg_wr_i  (cfg_wr_i),
        .cfg_ch_i  (cfg_ch_i),
        .cfg_shr_i (cfg_shr_i),
        .clr_i     (clr_i),
        .lp_o      (lp_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic set_data();
        data_i = {m_x[3], m_x[2], m_x[1], m_x[0]};
    endtask

    function automatic logic [7:0] f_step(input logic [7:0] lp, input logic [7:0] x, input int shr);
        int hp;
        int d;
        hp = int'(x) - int'(lp);
        d  = hp >>> shr;
        return 8'(int'(lp) + d);
    endfunction

    task automatic expect_sweep();
        for (int k = 0; k < CH; k++) begin
            m_lp[k] = f_step(m_lp[k], m_x[k], m_shr[k]);
        end
        sb.push_back({m_lp[3], m_lp[2], m_lp[1], m_lp[0]});
    endtask

    task automatic cfg(input int ch, input int val);
        cfg_wr_i  = 1'b1;
        cfg_ch_i  = 2'(ch);
        cfg_shr_i = 4'(val);
        cyc();
        cfg_wr_i  = 1'b0;
        m_shr[ch] = val;
    endtask

    // One strobe, optional config write at edge E(cfg_edge), wait for done.
    task automatic run_sweep(input int cfg_edge, input int cch, input int cval);
        int n;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        chk("busy_after_e0", 32'(busy_o), 32'd1);
        n = 0;
        while (done_o !== 1'b1 && n < 20) begin
            if (n + 1 == cfg_edge) begin
                cfg_wr_i  = 1'b1;
                cfg_ch_i  = 2'(cch);
                cfg_shr_i = 4'(cval);
            end
            cyc();
            cfg_wr_i = 1'b0;
            n++;
        end
        chk("done_latency", 32'(n), 32'd5);
        chk("busy_at_done", 32'(busy_o), 32'd0);
    endtask

    // Strobes at E0 and E2 (queued), optionally E3 (dropped).
    task automatic b2b(input bit third);
        int e;
        int nd;
        int d1;
        int d2;
        expect_sweep();
        expect_sweep();
        start_i = 1'b1; cyc();
        start_i = 1'b0; cyc();
        start_i = 1'b1; cyc();
        start_i = third; cyc();
        start_i = 1'b0;
        chk("ovf_after_e3", 32'(ovf_o), 32'(third));
        e  = 3;
        nd = 0;
        d1 = 0;
        d2 = 0;
        while (e < 16) begin
            cyc();
            e++;
            if (done_o === 1'b1) begin
                if (nd == 0) d1 = e;
                else d2 = e;
                nd++;
            end
        end
        chk("b2b_ndone", 32'(nd), 32'd2);
        chk("b2b_done1_edge", 32'(d1), 32'd5);
        chk("b2b_done2_edge", 32'(d2), 32'd11);
        chk("ovf_hold", 32'(ovf_o), 32'(third));
    endtask

    // Scoreboard consumer: every done_o pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            chk("done_has_expect", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("sweep_lp", lp_o, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i   = 1'b0;
        start_i   = 1'b0;
        cfg_wr_i  = 1'b0;
        cfg_ch_i  = 2'd0;
        cfg_shr_i = 4'd0;
        clr_i     = 1'b0;
        exp_ch1[0] = 8'h0F;
        exp_ch1[1] = 8'h1E;
        exp_ch1[2] = 8'h2C;
        for (int k = 0; k < CH; k++) begin
            m_lp[k]  = 8'h00;
            m_x[k]   = 8'h00;
            m_shr[k] = 4;
        end
        set_data();
        repeat (3) cyc();
        chk("rst_lp", lp_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        rst_n_i = 1'b1;
        cyc();

        // shr=0 passes the sample straight through; other channels stay 0.
        cfg(0, 0);
        m_x[0] = 8'h80;
        set_data();
        expect_sweep();
        run_sweep(-1, 0, 0);
        chk("ch0_passthru", lp_o, 32'h0000_0080);

        // Step response with shift 4 on channel 1.
        cfg(1, 4);
        m_x[1] = 8'hFF;
        set_data();
        for (int i = 0; i < 3; i++) begin
            expect_sweep();
            run_sweep(-1, 0, 0);
            chk("ch1_step", 32'(lp_o[15:8]), 32'(exp_ch1[i]));
        end

        // Negative high-pass term, then an oversized shift (step down by 1).
        cfg(2, 0);
        m_x[2] = 8'h80;
        set_data();
        expect_sweep();
        run_sweep(-1, 0, 0);
        chk("ch2_load", 32'(lp_o[23:16]), 32'h80);
        cfg(2, 1);
        m_x[2] = 8'h00;
        set_data();
        expect_sweep();
        run_sweep(-1, 0, 0);
        chk("ch2_neg_shr1", 32'(lp_o[23:16]), 32'h40);
        cfg(2, 15);
        expect_sweep();
        run_sweep(-1, 0, 0);
        chk("ch2_neg_shr15", 32'(lp_o[23:16]), 32'h3F);

        // Back-to-back starts, without and with a dropped third request.
        b2b(1'b0);
        b2b(1'b1);
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        chk("ovf_cleared", 32'(ovf_o), 32'd0);

        // Config write at E2 reaches channel 3 (issued at E4).
        m_x[3] = 8'h55;
        set_data();
        m_shr[3] = 0;
        expect_sweep();
        run_sweep(2, 3, 0);
        chk("cfg_at_e2", 32'(lp_o[31:24]), 32'h55);

        // Config write at E4 is too late for this sweep's channel 3.
        m_x[3] = 8'hAA;
        set_data();
        expect_sweep();
        run_sweep(4, 3, 4);
        m_shr[3] = 4;
        chk("cfg_at_e4", 32'(lp_o[31:24]), 32'hAA);

        // Reset between E2 and E3 aborts the sweep.
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        cyc();
        cyc();
        rst_n_i = 1'b0;
        #1;
        chk("midrst_lp", lp_o, 32'h0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        cyc();
        cyc();
        chk("midrst_no_done", 32'(done_o), 32'd0);
        rst_n_i = 1'b1;
        for (int k = 0; k < CH; k++) begin
            m_lp[k]  = 8'h00;
            m_shr[k] = 4;
        end
        cyc();

        // Fresh sweep after reset, default shift 4 everywhere.
        m_x[0] = 8'h10;
        m_x[1] = 8'h20;
        m_x[2] = 8'h30;
        m_x[3] = 8'h40;
        set_data();
        expect_sweep();
        run_sweep(-1, 0, 0);
        chk("post_rst_sweep", lp_o, 32'h0403_0201);

        repeat (3) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lpf_sched.md
# lpf_sched

Time-multiplexed scheduler for first-order unsigned "fast" low-pass IIR filters. It runs CH independent filter channels through one shared subtract/shift/accumulate datapath. Each sweep is triggered by a sample strobe, and each channel has its own run-time-configurable cutoff shift. It sits between the multi-channel sensor front end and downstream consumers, so we no longer need CH separate filter instances with their own hp/lp registers.

## Interface
- CH, 4: number of channels (≥2).
- DATA_W, 16: per-channel unsigned sample width.
- SHR_W, 4: width of the per-channel shift config.
- SHR_DEF, 4: reset value of every channel's shift.
- clk_i  in  1  clock.
- rst_n_i  in  1  async reset, active low.
- start_i  in  1  sample strobe; requests one sweep over all channels.
- data_i  in  CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- cfg_wr_i  in  1  shift config write strobe.
- cfg_ch_i  in  $clog2(CH)  config target channel.
- cfg_shr_i  in  SHR_W  config shift value.
- clr_i  in  1  clears ovf_o.
- lp_o  out  CH*DATA_W  filtered outputs, same packing as data_i.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse when a sweep completes.
- ovf_o  out  1  sticky: a start request was dropped.

## Operation
- Reset (async, rst_n_i low):
  - lp[all] = 0, shr[all] = SHR_DEF.
  - State = IDLE; pending, ovf_o, done_o and busy_o = 0.
  - Pipeline valid bits = 0.
- State machine states:
  - IDLE: on start_i or pending, snapshot all of data_i into an internal register, clear pending, set ch = 0, go to RUN.
  - RUN: issue one channel per cycle in order ch = 0..CH-1. After issuing CH-1, go to DRAIN.
  - DRAIN: one cycle; the last writeback completes. Then go to IDLE.
- Stage 1 (issue), shared datapath:
  - hp = signed(DATA_W+1)(snap[ch]) − lp[ch].
  - hp_shr = hp >>> shr[ch] (arithmetic shift).
  - Register hp_shr and ch.
- Stage 2 (writeback): lp[ch_r] = DATA_W'(lp[ch_r] + hp_shr_r), truncated.
  - No read-after-write hazard: each channel is touched once per sweep.
- shr = 0: lp takes the snapshot value directly.
- shr ≥ DATA_W+1: hp_shr is 0 for non-negative hp and −1 for negative hp, so lp steps down by 1.
- Start handling:
  - start_i while busy_o = 1 and pending = 0: set pending.
  - start_i while pending = 1: drop the request and set ovf_o.
  - ovf_o holds until clr_i. If clr_i and an overflow event occur in the same cycle, set wins.
- Config:
  - cfg_wr_i writes shr[cfg_ch_i] at any time.
  - The new value applies to any issue on a later edge. A channel already issued this sweep uses the old value.
  - Config writes never alter lp.
- lp_o is driven directly from the lp registers; each channel field updates at its own writeback edge.

## Timing
- Sweep edges:
  - E0: start accepted (edge where IDLE sees start_i or pending).
  - Issue of channel k: edge E(k+1).
  - Writeback of channel k: edge E(k+2).
- done_o is high for exactly one cycle, starting at E(CH+1). At that point lp_o holds all of the sweep's results.
- busy_o is high from E0 up to E(CH+1), then low.
- A pending start is accepted at E(CH+2). Back-to-back sweep period is therefore CH+2 cycles.
- start_i coincident with E(CH+1) (the DRAIN→IDLE edge) sets pending; it does not count as a direct start.
- Input sampling:
  - data_i is sampled only at E0; changes during a sweep are ignored.
  - start_i is level-sampled each edge. A strobe held k cycles counts as k requests.
- Reset mid-sweep: all state returns to reset values immediately. No done_o is issued, and partial writebacks are discarded (lp = 0).

## Test plan
- Bench configuration for all scenarios: CH=4, DATA_W=8.
- Reset, then shr[0] = 0, data ch0 = 0x80, start pulse: done_o at E5 and lp0 = 0x80. Channels 1–3 (shr = 4, data 0) stay at 0x00.
- shr[1] = 4, data ch1 = 0xFF held, three sweeps: lp1 = 0x0F, then 0x1E, then 0x2C. Differences 255, 240, 225 shifted right by 4 give 15, 15, 14.
- Negative hp: lp2 = 0x80, data ch2 = 0x00, shr[2] = 1, one sweep: lp2 = 0x40. Then shr[2] = 15 with lp2 = 0x40 and data 0x00: lp2 steps down by 1 to 0x3F.
- Back-to-back starts:
  - start at E0 and again at E2: done_o pulses at E5 and E11, ovf_o stays 0.
  - A third start at E3: ovf_o goes to 1 and stays set until clr_i.
- Config mid-sweep: write shr[3] = 0 at edge E2, data ch3 = 0x55. This sweep updates ch3 with the new shift (ch3 issues at E4), giving lp3 = 0x55. A write at edge E4 instead leaves the old shift in effect for this sweep.
- Drive rst_n_i low between E2 and E3: all lp_o = 0, busy_o = 0, no done_o. After release, a fresh start completes normally.
